// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: the per-stage stall/flush bundle
// and the fetch-discard FSM state encoding.
package pipe_ctrl_pkg;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
  } pctrl_t;

  typedef enum logic {
    FD_RUN     = 1'b0,
    FD_DISCARD = 1'b1
  } fd_state_t;

  localparam pctrl_t PCTRL_IDLE = '0;

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// Combinational hazard detection: load-use check plus the stall chain and
// bubble insertion for every inter-stage register. No state lives here.
module pipe_ctrl_hazard
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             mem_busy,
  input  logic             ex_busy,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_redirect,
  input  logic             fetch_wait,
  output pctrl_t           ctrl,
  output logic             take
);

  logic load_use;
  logic rs1_hit;
  logic rs2_hit;

  // Stall chain flows from MEM back to IF; a bubble goes into a register
  // only when that register is not itself being held.
  always_comb begin
    ctrl     = PCTRL_IDLE;
    rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
    load_use = ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

    ctrl.stall_mem = mem_busy;
    ctrl.stall_ex  = ctrl.stall_mem | ex_busy;
    ctrl.stall_id  = ctrl.stall_ex | load_use;
    ctrl.stall_if  = ctrl.stall_id | fetch_wait;

    // A redirect seen while EX is held is ignored; EX keeps presenting it.
    take = ex_redirect & ~ctrl.stall_ex;

    ctrl.flush_ex_mem = ex_busy & ~ctrl.stall_mem;
    ctrl.flush_id_ex  = (load_use & ~ctrl.stall_ex) | take;
    ctrl.flush_if_id  = take | (fetch_wait & ~ctrl.stall_id);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central hazard/stall/flush controller for the 5-stage pipeline. Owns the
// fetch-discard FSM, the redirect target register and two perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req_pending,
  input  logic             if_data_ok,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_busy,
  input  logic             mem_busy,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  ex_redirect_pc,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             drop_ifetch,
  output logic             pc_load,
  output logic [XLEN-1:0]  pc_target,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  fd_state_t        state_q, state_d;
  logic [XLEN-1:0]  tgt_q, tgt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  pctrl_t          ctrl;
  logic            take;
  logic            fetch_wait;
  logic            drop_raw;
  logic            load_raw;
  logic [XLEN-1:0] target_raw;

  assign fetch_wait = (state_q == FD_DISCARD) | (if_req_pending & ~if_data_ok);

  pipe_ctrl_hazard #(
    .REG_W(REG_W)
  ) u_hazard (
    .mem_busy   (mem_busy),
    .ex_busy    (ex_busy),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_redirect(ex_redirect),
    .fetch_wait (fetch_wait),
    .ctrl       (ctrl),
    .take       (take)
  );

  // Fetch-discard FSM next state and redirect outputs. A redirect that
  // lands while an imem request is still outstanding must wait for (and
  // throw away) that stale response before the PC can be reloaded.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    drop_raw   = 1'b0;
    load_raw   = 1'b0;
    target_raw = '0;
    unique case (state_q)
      FD_RUN: begin
        if (take) begin
          if (if_req_pending && !if_data_ok) begin
            tgt_d   = ex_redirect_pc;
            state_d = FD_DISCARD;
          end else begin
            drop_raw   = if_data_ok;
            load_raw   = 1'b1;
            target_raw = ex_redirect_pc;
          end
        end
      end
      FD_DISCARD: begin
        if (take) begin
          tgt_d = ex_redirect_pc;
        end
        if (if_data_ok) begin
          drop_raw   = 1'b1;
          load_raw   = 1'b1;
          target_raw = take ? ex_redirect_pc : tgt_q;
          state_d    = FD_RUN;
        end
      end
      default: state_d = FD_RUN;
    endcase
  end

  // Performance counters; both wrap naturally at CNT_W bits.
  always_comb begin
    stall_cnt_d = stall_cnt_q + (ctrl.stall_if ? CNT_W'(1) : CNT_W'(0));
    flush_cnt_d = flush_cnt_q + (take ? CNT_W'(1) : CNT_W'(0));
  end

  // Outputs are zero-latency, but forced quiet for as long as reset is held.
  always_comb begin
    stall_if       = ctrl.stall_if     & ~reset;
    stall_id       = ctrl.stall_id     & ~reset;
    stall_ex       = ctrl.stall_ex     & ~reset;
    stall_mem      = ctrl.stall_mem    & ~reset;
    flush_if_id    = ctrl.flush_if_id  & ~reset;
    flush_id_ex    = ctrl.flush_id_ex  & ~reset;
    flush_ex_mem   = ctrl.flush_ex_mem & ~reset;
    drop_ifetch    = drop_raw & ~reset;
    pc_load        = load_raw & ~reset;
    pc_target      = reset ? '0 : target_raw;
    perf_stall_cnt = reset ? '0 : stall_cnt_q;
    perf_flush_cnt = reset ? '0 : flush_cnt_q;
  end

  // State, target and counter registers. A reset during DISCARD drops the
  // pending target on purpose.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FD_RUN;
      tgt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
